// File: rtl/zorro_pkg.sv
// zorro_pkg: shared state encodings and strobe constants for the Zorro III master sequencer.
package zorro_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_TERM    = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [3:0] DS_IDLE   = 4'hF;
endpackage

// File: rtl/zorro_sync2.sv
// zorro_sync2: two-flop synchronizer with asynchronous reset to a chosen level.
module zorro_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/zorro_master_cycle.sv
// zorro_master_cycle: turns local master requests into complete Zorro III bus cycles.
module zorro_master_cycle
  import zorro_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        MYBUS_n,
  input  logic        L_REQ,
  input  logic        L_WRITE,
  input  logic [31:0] L_ADDR,
  input  logic [3:0]  L_BE,
  input  logic [31:0] L_WDATA,
  output logic [31:0] L_RDATA,
  output logic        L_ACK,
  output logic        L_ERR,
  output logic        FCS_ACT,
  output logic [31:0] Z_ADDR,
  output logic        Z_ADDR_OE,
  output logic        Z_READ,
  output logic        Z_FCS_n,
  output logic [3:0]  Z_DS_n,
  output logic        Z_DOE,
  output logic [31:0] Z_DATA_OUT,
  output logic        Z_DATA_OE,
  input  logic [31:0] Z_DATA_IN,
  input  logic        Z_DTACK_n,
  input  logic        Z_BERR_n
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    be;
  logic          dtack_s, berr_s;
  zorro_sync2 #(.RST_VAL(1'b0)) u_dtack (.CLK(CLK), .RESET_n(RESET_n), .d(~Z_DTACK_n), .q(dtack_s));
  zorro_sync2 #(.RST_VAL(1'b0)) u_berr  (.CLK(CLK), .RESET_n(RESET_n), .d(~Z_BERR_n),  .q(berr_s));
  assign FCS_ACT = ~Z_FCS_n;
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      be         <= '0;
      Z_ADDR     <= '0;
      Z_DATA_OUT <= '0;
      Z_READ     <= 1'b1;
      Z_ADDR_OE  <= 1'b0;
      Z_FCS_n    <= 1'b1;
      Z_DS_n     <= DS_IDLE;
      Z_DOE      <= 1'b0;
      Z_DATA_OE  <= 1'b0;
      L_RDATA    <= '0;
      L_ACK      <= 1'b0;
      L_ERR      <= 1'b0;
    end else begin
      L_ACK <= 1'b0;
      case (state)
        S_IDLE:
          if (L_REQ && !MYBUS_n) begin
            state      <= S_ADDR;
            Z_ADDR     <= L_ADDR;
            Z_READ     <= ~L_WRITE;
            Z_DATA_OUT <= L_WDATA;
            be         <= L_BE;
            Z_ADDR_OE  <= 1'b1;
          end
        S_ADDR:
          if (MYBUS_n) begin
            state     <= S_IDLE;
            Z_ADDR_OE <= 1'b0;
          end else begin
            state   <= S_STROBE;
            Z_FCS_n <= 1'b0;
          end
        S_STROBE: begin
          state     <= S_DATA;
          Z_DOE     <= 1'b1;
          Z_DS_n    <= Z_READ ? 4'h0 : ~be;
          Z_DATA_OE <= ~Z_READ;
          cnt       <= '0;
        end
        S_DATA:
          if (berr_s || dtack_s || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            // BERR outranks DTACK; a timeout without either is an error
            state     <= S_TERM;
            L_ACK     <= 1'b1;
            L_ERR     <= berr_s || !dtack_s;
            L_RDATA   <= (dtack_s && !berr_s && Z_READ) ? Z_DATA_IN : L_RDATA;
            Z_FCS_n   <= 1'b1;
            Z_DS_n    <= DS_IDLE;
            Z_DOE     <= 1'b0;
            Z_DATA_OE <= 1'b0;
            Z_ADDR_OE <= 1'b0;
          end else cnt <= cnt + 1'b1;
        S_TERM:
          state <= S_RELEASE;
        S_RELEASE:
          if (!dtack_s && !berr_s) state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/zorro_master_cycle.md
# zorro_master_cycle

Zorro III master cycle sequencer, directly downstream of the bus arbiter. It turns a local master request from the SCSI side into a complete Zorro III bus cycle: address phase, FCS, data strobes and DTACK/BERR termination. It starts a cycle only while the arbiter reports bus ownership (MYBUS_n low) and feeds `FCS_ACT` back so the arbiter holds ownership until the cycle completes.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum CLK cycles spent in DATA before forced error termination (≥2).
- `CLK` in 1: local bus clock; all state on rising edge.
- `RESET_n` in 1: reset, asynchronous, active-low.
- `MYBUS_n` in 1: bus owned, from arbiter, active low; already synchronous to CLK.
- `L_REQ` in 1: local cycle request, level, held with address/data until `L_ACK`.
- `L_WRITE` in 1: 1 = write, 0 = read.
- `L_ADDR` in 32: cycle address.
- `L_BE` in 4: byte enables, active high, bit 3 = D31:24.
- `L_WDATA` in 32: write data.
- `L_RDATA` out 32: read data, valid while `L_ACK`=1.
- `L_ACK` out 1: one-cycle completion pulse.
- `L_ERR` out 1: error flag, qualified by `L_ACK`.
- `FCS_ACT` out 1: equals ~`Z_FCS_n`; goes to the arbiter FCS input.
- `Z_ADDR` out 32; `Z_ADDR_OE` out 1: address bus and its enable.
- `Z_READ` out 1: Zorro READ, 1 = read.
- `Z_FCS_n` out 1; `Z_DS_n` out 4; `Z_DOE` out 1: strobes and data output enable.
- `Z_DATA_OUT` out 32; `Z_DATA_OE` out 1: write data and its enable.
- `Z_DATA_IN` in 32: read data from bus.
- `Z_DTACK_n` in 1; `Z_BERR_n` in 1: asynchronous slave responses.

## Operation
- `Z_DTACK_n` and `Z_BERR_n` each pass through a 2-flop synchronizer, giving `dtack_s` and `berr_s`, both active high. Reset value of both is 0 (negated).
- The state machine has six states: IDLE, ADDR, STROBE, DATA, TERM, RELEASE.
- **IDLE:**
  - If `L_REQ` & ~`MYBUS_n`, go to ADDR.
  - On that transition, register `Z_ADDR` from `L_ADDR`, `Z_READ` from ~`L_WRITE`, `Z_DATA_OUT` from `L_WDATA`, and latch `L_BE`.
  - Set `Z_ADDR_OE`=1.
- **ADDR:** address setup.
  - If `MYBUS_n`=1, abort to IDLE: `Z_ADDR_OE`=0, no `L_ACK`.
  - Otherwise go to STROBE with `Z_FCS_n`=0.
- **STROBE:** address hold, then go to DATA.
  - Set `Z_DOE`=1.
  - Set `Z_DS_n` = ~BE for writes, 4'h0 for reads.
  - Set `Z_DATA_OE` = write.
  - Clear the timeout counter.
- **DATA:** each cycle, evaluate in priority order:
  1. `berr_s`: go to TERM with `L_ERR`=1.
  2. `dtack_s`: go to TERM with `L_ERR`=0; on a read, capture `L_RDATA` from `Z_DATA_IN`.
  3. Counter == `TIMEOUT_CYCLES`-1: go to TERM with `L_ERR`=1.
  4. Otherwise increment the counter.
- **TERM:**
  - `L_ACK`=1 for this single cycle.
  - `Z_FCS_n`=1, `Z_DS_n`=4'hF, `Z_DOE`=0, `Z_DATA_OE`=0, `Z_ADDR_OE`=0.
  - Go to RELEASE.
- **RELEASE:** `L_ACK`=0. Wait for ~`dtack_s` & ~`berr_s`, then go to IDLE. This prevents a stale DTACK from terminating the next cycle.
- **Read data:** `L_RDATA` holds its value until the next read capture.
- **Abort rule:** `MYBUS_n` is ignored once FCS is asserted, because the arbiter holds ownership while `FCS_ACT`=1.
- **Timeout counter:** width is $clog2(`TIMEOUT_CYCLES`); it never wraps.

## Timing
- **Reset values:** `Z_FCS_n`=1, `Z_DS_n`=4'hF, `Z_READ`=1, `Z_DOE`=0, `Z_ADDR_OE`=0, `Z_DATA_OE`=0, `Z_ADDR`=0, `Z_DATA_OUT`=0, `L_RDATA`=0, `L_ACK`=0, `L_ERR`=0, `FCS_ACT`=0, state IDLE.
- **Asynchronous reset:** asserting `RESET_n` in any state forces these values immediately. No `L_ACK` is generated for the interrupted cycle.
- **Cycle latency:** all outputs are registered. Call edge E0 the edge that accepts the request.
  - After E0: address valid.
  - After E0+1: FCS low.
  - After E0+2: DS and DOE asserted.
- **DTACK latency:** DTACK falling before edge k is seen in DATA at edge k+1. `L_ACK` is high after edge k+2.
- **Minimum cycle:** IDLE to IDLE takes 6 CLK cycles when DTACK is already low at STROBE, plus the release wait.
- **Requester rule:** the requester drops `L_REQ` in the `L_ACK` cycle. IDLE is reached no earlier than 2 cycles after `L_ACK`, so no double issue is possible.

## Structure
- Shared package/include `zorro_pkg`: state encoding constants; `DS_IDLE`=4'hF.
- Sub-module `zorro_sync2`: 2-flop synchronizer with asynchronous reset and a parameterized reset value, instantiated twice.

## Test plan
- **Read, DTACK after 3 cycles in DATA.** `L_ADDR`=32'h4000_0010, `Z_DATA_IN`=32'hDEAD_BEEF.
  - Expect FCS low after E0+1 and DS=4'h0 after E0+2.
  - Expect `L_ACK` pulse with `L_RDATA`=32'hDEAD_BEEF and `L_ERR`=0.
- **Write, `L_BE`=4'b0011.**
  - Expect `Z_DS_n`=4'b1100, `Z_DATA_OE`=1 and `Z_READ`=0 during DATA.
  - All drop together in TERM.
- **No DTACK, `TIMEOUT_CYCLES`=8.**
  - Expect exactly 8 DATA cycles, then `L_ACK` with `L_ERR`=1, and FCS negated.
- **BERR and DTACK asserted on the same edge.**
  - Expect `L_ERR`=1.
  - Expect RELEASE to hold until both negate; hold DTACK 5 extra cycles and check there is no new cycle.
- **`MYBUS_n` rises during ADDR.**
  - Expect return to IDLE, no FCS, no `L_ACK`, `Z_ADDR_OE`=0.
- **`RESET_n` pulsed mid-DATA.**
  - Expect all outputs at reset values asynchronously.
  - The next request completes normally.
